// File: rtl/key_event_arbiter_if.sv
// key_event_arbiter_if: event handshake and status bundle between the keypad
// front end (master) and the calculator control FSM (slave).
interface key_event_arbiter_if #(
  parameter int N_KEYS = 8,
  parameter int CODE_W = 3
);
  logic              key_valid;
  logic [CODE_W-1:0] key_code;
  logic              key_ready;
  logic [N_KEYS-1:0] pending;
  logic              overrun;

  modport master (
    output key_valid,
    output key_code,
    output pending,
    output overrun,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  pending,
    input  overrun,
    output key_ready
  );
endinterface

// File: rtl/key_event_arbiter.sv
// key_event_arbiter: keypad front end.
// Each raw button is synchronized, debounced and watched for a release (stable
// level falling 1 -> 0). A release latches one pending event per key; pending
// events are offered one at a time, round-robin, over a valid/ready handshake.
// A second event on a key that is still pending is dropped and sets the sticky
// overrun flag.
// Optional macro KEY_REPEAT_EN: while a key is held stable, auto-repeat events
// are generated after REPEAT_DELAY clocks and then every REPEAT_PERIOD clocks.
module key_event_arbiter #(
  parameter int N_KEYS          = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CODE_W          = 3,
  parameter int REPEAT_DELAY    = 1000,
  parameter int REPEAT_PERIOD   = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_KEYS-1:0]   key_in,
  key_event_arbiter_if.master bus
);

  localparam int                DB_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(N_KEYS - 1);
  localparam logic [CODE_W:0]   NK        = (CODE_W + 1)'(N_KEYS);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  // One-clock event pulse per key, out of the per-key pipeline.
  logic [N_KEYS-1:0] key_evt;
  // Second event stage: separates per-key logic from the shared pending logic.
  logic [N_KEYS-1:0] evt_reg;

  logic [N_KEYS-1:0] pending_reg;
  logic [N_KEYS-1:0] pending_next;
  logic              overrun_reg;
  logic              overrun_hit;

  state_t            state_reg;
  state_t            state_next;
  logic              valid_reg;
  logic              valid_next;
  logic [CODE_W-1:0] code_reg;
  logic [CODE_W-1:0] code_next;
  logic [CODE_W-1:0] ptr_reg;
  logic [CODE_W-1:0] ptr_next;

  logic              handshake;
  logic [N_KEYS-1:0] clear_vec;

  logic [2*N_KEYS-1:0] rot_pending;
  logic                grant_found;
  logic [CODE_W-1:0]   grant_off;
  logic [CODE_W:0]     grant_sum;
  logic [CODE_W-1:0]   grant_idx;

  // ---------------------------------------------------------------------------
  // Per-key conditioning: synchronizer, debounce, release / repeat detection
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    logic            sync1_reg;
    logic            sync2_reg;
    logic            stable_reg;
    logic            stable_prev_reg;
    logic            rel_reg;
    logic [DB_W-1:0] db_cnt_reg;
    logic            fall;
    logic            evt_src;

    // Two-flop synchronizer for the asynchronous button level.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
      end else begin
        sync1_reg <= key_in[gi];
        sync2_reg <= sync1_reg;
      end
    end

    // Debounce: stable level follows only after DEBOUNCE_CYCLES differing samples in a row.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable_reg <= 1'b0;
        db_cnt_reg <= '0;
      end else if (sync2_reg != stable_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          stable_reg <= sync2_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end

    // Release detect: previous stable 1, current stable 0 (presses are ignored).
    assign fall = stable_prev_reg & ~stable_reg;

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_reg;
    logic             rep_first_reg;
    logic             rep_fire;

    // The first repeat waits REPEAT_DELAY, later repeats REPEAT_PERIOD.
    assign rep_fire = stable_reg &&
                      (rep_cnt_reg == (rep_first_reg ? REP_W'(REPEAT_DELAY - 1)
                                                     : REP_W'(REPEAT_PERIOD - 1)));

    // Repeat timer runs only while the key is held; restarts on every release.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rep_cnt_reg   <= '0;
        rep_first_reg <= 1'b1;
      end else if (!stable_reg) begin
        rep_cnt_reg   <= '0;
        rep_first_reg <= 1'b1;
      end else if (rep_fire) begin
        rep_cnt_reg   <= '0;
        rep_first_reg <= 1'b0;
      end else begin
        rep_cnt_reg   <= rep_cnt_reg + 1'b1;
      end
    end

    assign evt_src = fall | rep_fire;
`else
    assign evt_src = fall;
`endif

    // Edge-detect history and registered event pulse.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stable_prev_reg <= 1'b0;
        rel_reg         <= 1'b0;
      end else begin
        stable_prev_reg <= stable_reg;
        rel_reg         <= evt_src;
      end
    end

    assign key_evt[gi] = rel_reg;
  end

  // ---------------------------------------------------------------------------
  // Pending bitmap and overrun
  // ---------------------------------------------------------------------------
  assign handshake = valid_reg & bus.key_ready;
  assign clear_vec = handshake ? (N_KEYS'(1) << code_reg) : '0;

  // A new event beats a same-cycle clear; an event on an uncleared pending key is lost.
  assign pending_next = (pending_reg & ~clear_vec) | evt_reg;
  assign overrun_hit  = |(evt_reg & pending_reg & ~clear_vec);

  // Event stage, pending bitmap and sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_reg     <= '0;
      pending_reg <= '0;
      overrun_reg <= 1'b0;
    end else begin
      evt_reg     <= key_evt;
      pending_reg <= pending_next;
      overrun_reg <= overrun_reg | overrun_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first pending key at or above the pointer, with wrap
  // ---------------------------------------------------------------------------
  assign rot_pending = {pending_reg, pending_reg} >> ptr_reg;

  // Lowest set bit of the rotated bitmap is the offset from the pointer.
  always_comb begin
    grant_found = 1'b0;
    grant_off   = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (!grant_found && rot_pending[k]) begin
        grant_found = 1'b1;
        grant_off   = CODE_W'(k);
      end
    end
  end

  assign grant_sum = {1'b0, ptr_reg} + {1'b0, grant_off};
  assign grant_idx = (grant_sum >= NK) ? CODE_W'(grant_sum - NK) : grant_sum[CODE_W-1:0];

  // ---------------------------------------------------------------------------
  // Arbiter FSM
  // ---------------------------------------------------------------------------
  // Next state: latch a grant in IDLE, hold the offer until it is taken.
  always_comb begin
    state_next = state_reg;
    valid_next = valid_reg;
    code_next  = code_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        if (grant_found) begin
          code_next  = grant_idx;
          valid_next = 1'b1;
          state_next = OFFER;
        end
      end
      OFFER: begin
        if (bus.key_ready) begin
          valid_next = 1'b0;
          ptr_next   = (code_reg == LAST_CODE) ? '0 : code_reg + 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        valid_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // FSM state, offered code and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      code_reg  <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= valid_next;
      code_reg  <= code_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign bus.key_valid = valid_reg;
  assign bus.key_code  = code_reg;
  assign bus.pending   = pending_reg;
  assign bus.overrun   = overrun_reg;

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb_key_event_arbiter: directed scenarios plus a randomized run, all checked
// every cycle against an event-level reference model of the keypad front end.
module tb_key_event_arbiter;
  localparam int N  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;

  key_event_arbiter_if #(.N_KEYS(N), .CODE_W(CW)) bus ();

  key_event_arbiter #(
    .N_KEYS(N), .DEBOUNCE_CYCLES(D), .CODE_W(CW),
    .REPEAT_DELAY(1000), .REPEAT_PERIOD(250)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (values as seen after the most recent clock edge).
  int           edge_n = 0;
  logic [N-1:0] m_pend;
  logic         m_valid;
  int           m_code;
  int           m_ptr;
  logic         m_ovr;
  logic [N-1:0] m_stable;
  int           m_run [N];
  int           m_evt_edge [N];
  logic [N-1:0] sched [int];

  logic [N-1:0] cur_keys;
  logic         cur_rdy;
  int           hs_log [$];

  task automatic model_reset();
    m_pend = '0; m_valid = 1'b0; m_code = 0; m_ptr = 0; m_ovr = 1'b0;
    m_stable = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_evt_edge[i] = -1;
    end
    sched.delete();
  endtask

  // Check DUT against model, apply inputs, advance the model over one edge.
  task automatic tick(input logic [N-1:0] keys, input logic rdy);
    logic [N-1:0] ev;
    logic [N-1:0] np;
    logic [N-1:0] tmp;
    logic         hs;
    logic         found;
    int           j;
    n_checks += 4;
    if (bus.key_valid !== m_valid) begin
      n_fail++;
      $display("FAIL key_valid @edge %0d: got %b expected %b", edge_n, bus.key_valid, m_valid);
    end
    if (bus.key_code !== CW'(m_code)) begin
      n_fail++;
      $display("FAIL key_code @edge %0d: got %0d expected %0d", edge_n, bus.key_code, m_code);
    end
    if (bus.pending !== m_pend) begin
      n_fail++;
      $display("FAIL pending @edge %0d: got %b expected %b", edge_n, bus.pending, m_pend);
    end
    if (bus.overrun !== m_ovr) begin
      n_fail++;
      $display("FAIL overrun @edge %0d: got %b expected %b", edge_n, bus.overrun, m_ovr);
    end
    if (bus.key_valid === 1'b1 && rdy) begin
      hs_log.push_back(int'(bus.key_code));
      $display("edge %0d: handshake key %0d", edge_n + 1, bus.key_code);
    end

    key_in        = keys;
    bus.key_ready = rdy;

    edge_n++;
    // A level must be seen D consecutive samples to become stable; a stable
    // fall reaches the pending bitmap five edges after that D-th sample.
    for (int i = 0; i < N; i++) begin
      if (keys[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          if (m_stable[i]) begin
            tmp = sched.exists(edge_n + 5) ? sched[edge_n + 5] : '0;
            tmp[i] = 1'b1;
            sched[edge_n + 5] = tmp;
            m_evt_edge[i] = edge_n + 5;
          end
          m_stable[i] = keys[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    ev = sched.exists(edge_n) ? sched[edge_n] : '0;
    hs = m_valid && rdy;
    np = m_pend;
    for (int i = 0; i < N; i++) begin
      if (ev[i]) begin
        if (m_pend[i] && !(hs && m_code == i)) m_ovr = 1'b1;
        np[i] = 1'b1;
      end else if (hs && m_code == i) begin
        np[i] = 1'b0;
      end
    end
    if (!m_valid) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (!found && m_pend[j]) begin
          found = 1'b1;
          m_code = j;
        end
      end
      m_valid = found;
    end else if (rdy) begin
      m_valid = 1'b0;
      m_ptr = (m_code + 1) % N;
    end
    m_pend = np;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(cur_keys, cur_rdy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = '0;
    bus.key_ready = 1'b0;
    cur_keys = '0;
    cur_rdy = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL reset key_valid: got %b expected 0", bus.key_valid); end
    if (bus.key_code !== 3'd0)  begin n_fail++; $display("FAIL reset key_code: got %0d expected 0", bus.key_code); end
    if (bus.pending !== 8'h00)  begin n_fail++; $display("FAIL reset pending: got %b expected 0", bus.pending); end
    if (bus.overrun !== 1'b0)   begin n_fail++; $display("FAIL reset overrun: got %b expected 0", bus.overrun); end
    rst = 1'b0;
    run(4);
  endtask

  task automatic test_single_release();
    int rel_edge;
    int pend_edge;
    int valid_edge;
    hs_log.delete();
    cur_rdy = 1'b1;
    cur_keys[3] = 1'b1;
    run(20);
    cur_keys[3] = 1'b0;
    rel_edge = edge_n + 1;
    pend_edge = -1;
    valid_edge = -1;
    for (int t = 0; t < 20; t++) begin
      tick(cur_keys, cur_rdy);
      if (pend_edge < 0 && bus.pending[3] === 1'b1) pend_edge = edge_n;
      if (valid_edge < 0 && bus.key_valid === 1'b1 && bus.key_code === 3'd3) valid_edge = edge_n;
    end
    n_checks += 4;
    if (pend_edge != rel_edge + 8) begin n_fail++; $display("FAIL single pending latency: got edge %0d expected %0d", pend_edge, rel_edge + 8); end
    if (valid_edge != rel_edge + 9) begin n_fail++; $display("FAIL single valid latency: got edge %0d expected %0d", valid_edge, rel_edge + 9); end
    if (hs_log.size() != 1 || hs_log[0] != 3) begin n_fail++; $display("FAIL single handshakes: got %0d entries expected one of key 3", hs_log.size()); end
    if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL single pending after: got %b expected 0", bus.pending); end
  endtask

  task automatic test_bounce();
    hs_log.delete();
    cur_rdy = 1'b1;
    for (int t = 0; t < 10; t++) begin
      cur_keys[5] = ~cur_keys[5];
      tick(cur_keys, cur_rdy);
    end
    cur_keys[5] = 1'b0;
    run(20);
    n_checks += 3;
    if (hs_log.size() != 0)   begin n_fail++; $display("FAIL bounce events: got %0d expected 0", hs_log.size()); end
    if (bus.pending !== 8'h00) begin n_fail++; $display("FAIL bounce pending: got %b expected 0", bus.pending); end
    if (bus.overrun !== 1'b0)  begin n_fail++; $display("FAIL bounce overrun: got %b expected 0", bus.overrun); end
  endtask

  task automatic test_round_robin();
    logic       vq [$];
    int         f;
    logic [4:0] pat;
    cur_rdy = 1'b1;
    // Serving key 4 first leaves the pointer at 5.
    cur_keys[4] = 1'b1; run(8);
    cur_keys[4] = 1'b0; run(16);
    hs_log.delete();
    cur_keys = 8'b0101_0010; run(8);
    cur_keys = 8'h00;
    for (int t = 0; t < 25; t++) begin
      tick(cur_keys, cur_rdy);
      vq.push_back(bus.key_valid);
    end
    n_checks += 2;
    if (hs_log.size() != 3 || hs_log[0] != 6 || hs_log[1] != 1 || hs_log[2] != 4) begin
      n_fail++;
      $display("FAIL rr order: got %0d events (first %0d) expected 6,1,4", hs_log.size(), (hs_log.size() > 0) ? hs_log[0] : -1);
    end
    f = -1;
    for (int i = 0; i < vq.size(); i++) if (f < 0 && vq[i] === 1'b1) f = i;
    pat = '0;
    if (f >= 0 && f + 4 < vq.size()) pat = {vq[f], vq[f+1], vq[f+2], vq[f+3], vq[f+4]};
    if (pat !== 5'b10101) begin n_fail++; $display("FAIL rr valid cadence: got %b expected 10101", pat); end
  endtask

  task automatic test_collision();
    int  rel2;
    logic r;
    logic coll_checked;
    hs_log.delete();
    cur_rdy = 1'b0;
    cur_keys[0] = 1'b1; run(8);
    cur_keys[0] = 1'b0; run(14);
    cur_keys[0] = 1'b1; run(8);
    cur_keys[0] = 1'b0;
    rel2 = edge_n + 1;
    coll_checked = 1'b0;
    for (int t = 0; t < 30; t++) begin
      r = (m_evt_edge[0] > rel2) && (edge_n + 1 >= m_evt_edge[0]);
      tick(cur_keys, r);
      if (!coll_checked && m_evt_edge[0] > rel2 && edge_n == m_evt_edge[0]) begin
        coll_checked = 1'b1;
        n_checks += 2;
        if (bus.pending[0] !== 1'b1) begin n_fail++; $display("FAIL collision pending[0]: got %b expected 1", bus.pending[0]); end
        if (bus.overrun !== 1'b0)    begin n_fail++; $display("FAIL collision overrun: got %b expected 0", bus.overrun); end
      end
    end
    n_checks += 1;
    if (hs_log.size() != 2 || hs_log[0] != 0 || hs_log[1] != 0) begin
      n_fail++;
      $display("FAIL collision deliveries: got %0d expected 2 of key 0", hs_log.size());
    end
    cur_rdy = 1'b1;
  endtask

  task automatic test_backpressure_overrun();
    hs_log.delete();
    cur_rdy = 1'b0;
    cur_keys[2] = 1'b1; run(8);
    cur_keys[2] = 1'b0; run(12);
    cur_keys[2] = 1'b1; run(8);
    cur_keys[2] = 1'b0; run(15);
    n_checks += 3;
    if (bus.key_valid !== 1'b1) begin n_fail++; $display("FAIL bp key_valid: got %b expected 1", bus.key_valid); end
    if (bus.key_code !== 3'd2)  begin n_fail++; $display("FAIL bp key_code: got %0d expected 2", bus.key_code); end
    if (bus.overrun !== 1'b1)   begin n_fail++; $display("FAIL bp overrun: got %b expected 1", bus.overrun); end
    cur_rdy = 1'b1;
    run(10);
    n_checks += 1;
    if (hs_log.size() != 1 || hs_log[0] != 2) begin n_fail++; $display("FAIL bp deliveries: got %0d expected one of key 2", hs_log.size()); end
  endtask

  task automatic test_async_reset();
    cur_rdy = 1'b0;
    cur_keys[1] = 1'b1; run(8);
    cur_keys[1] = 1'b0; run(12);
    #2 rst = 1'b1;
    #1;
    n_checks += 3;
    if (bus.key_valid !== 1'b0) begin n_fail++; $display("FAIL async key_valid: got %b expected 0", bus.key_valid); end
    if (bus.pending !== 8'h00)  begin n_fail++; $display("FAIL async pending: got %b expected 0", bus.pending); end
    if (bus.overrun !== 1'b0)   begin n_fail++; $display("FAIL async overrun: got %b expected 0", bus.overrun); end
    model_reset();
    cur_keys = 8'h80;
    key_in = cur_keys;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    cur_rdy = 1'b1;
    run(12);
    hs_log.delete();
    cur_keys[7] = 1'b0;
    run(20);
    n_checks += 1;
    if (hs_log.size() != 1 || hs_log[0] != 7) begin n_fail++; $display("FAIL async post-reset: got %0d events expected one of key 7", hs_log.size()); end
  endtask

  task automatic test_random();
    int tmr [N];
    for (int i = 0; i < N; i++) tmr[i] = $urandom_range(1, 14);
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        tmr[i]--;
        if (tmr[i] <= 0) begin
          cur_keys[i] = ~cur_keys[i];
          tmr[i] = $urandom_range(1, 14);
        end
      end
      cur_rdy = ($urandom_range(0, 3) != 0);
      tick(cur_keys, cur_rdy);
    end
    cur_keys = '0;
    cur_rdy = 1'b1;
    run(40);
  endtask

  initial begin
    test_reset();
    test_single_release();
    test_bounce();
    test_round_robin();
    test_collision();
    test_backpressure_overrun();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
